// File: rtl/bitstream_reader32.sv
// rtl/bitstream_reader32.sv - getbits front end over the 32-bit sample buffer with loader refill handshake
// Optional BITSTREAM_PEEK_EN adds PEEK_I for non-consuming (showbits) requests.
module bitstream_reader32 #(
    parameter int ADDR_W    = 9,
    parameter int NUM_WORDS = 512,
    parameter int DATA_W    = 32
) (
    input  logic              CLOCK_I,
    input  logic              RESETN_I,
    output logic [ADDR_W-1:0] MEM_ADDRESS_O,
    output logic              MEM_EN_O,
    input  logic [DATA_W-1:0] MEM_DATA_I,
    output logic              FILL_START_O,
    input  logic              FILL_DONE_I,
    input  logic              REQ_I,
    input  logic [5:0]        NBITS_I,
`ifdef BITSTREAM_PEEK_EN
    input  logic              PEEK_I,
`endif
    output logic [DATA_W-1:0] BITS_O,
    output logic              VALID_O,
    output logic              READY_O
);
    typedef enum logic [1:0] {REQ_FILL, WAIT_BUSY, WAIT_DONE, RUN} state_t;

    localparam logic [ADDR_W:0] LAST_PTR = NUM_WORDS[ADDR_W:0];
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    logic [ADDR_W:0] wptr;
    logic [6:0]      count;
    logic [63:0]     sr;
    logic            landing;
    logic [1:0]      stall_cnt;

    logic [6:0]  n7;
    logic        illegal;
    logic        take;
    logic        consume;
    logic        in_flight;
    logic        issue;
    logic        wrap;
    logic [6:0]  count_ex;
    logic [63:0] sr_ex;
    logic [31:0] field;

    // Valid bits sit left-aligned in sr; count says how many of the top bits are live.
    always_comb begin
        n7        = {1'b0, NBITS_I};
        illegal   = (NBITS_I == 6'd0) || (NBITS_I > 6'd32);
        take      = REQ_I && !VALID_O && (illegal || (count >= n7));
        consume   = take && !illegal;
`ifdef BITSTREAM_PEEK_EN
        consume   = consume && !PEEK_I;
`endif
        field     = illegal ? 32'd0 : 32'(sr >> (7'd64 - n7));
        count_ex  = consume ? (count - n7) : count;
        sr_ex     = consume ? (sr << n7) : sr;
        in_flight = MEM_EN_O || landing;
        issue     = (state == RUN) && !in_flight && (count <= 7'd32) && (wptr < LAST_PTR);
        wrap      = (state == RUN) && !in_flight && (wptr == LAST_PTR);
    end

    always_ff @(posedge CLOCK_I) begin
        if (!RESETN_I) begin
            state         <= REQ_FILL;
            wptr          <= '0;
            count         <= '0;
            sr            <= '0;
            landing       <= 1'b0;
            stall_cnt     <= '0;
            MEM_EN_O      <= 1'b0;
            MEM_ADDRESS_O <= '0;
            FILL_START_O  <= 1'b0;
            BITS_O        <= '0;
            VALID_O       <= 1'b0;
            READY_O       <= 1'b0;
        end else begin
            FILL_START_O <= 1'b0;
            MEM_EN_O     <= issue;
            landing      <= MEM_EN_O;
            VALID_O      <= take;
            if (take) begin
                BITS_O <= field;
            end
            if (issue) begin
                MEM_ADDRESS_O <= wptr[ADDR_W-1:0];
                wptr          <= wptr + PTR_ONE;
            end
            // Landing word goes directly below whatever survives this cycle's extract.
            if (landing) begin
                sr    <= sr_ex | ({MEM_DATA_I, 32'd0} >> count_ex);
                count <= count_ex + 7'd32;
            end else begin
                sr    <= sr_ex;
                count <= count_ex;
            end
            case (state)
                REQ_FILL: begin
                    FILL_START_O <= 1'b1;
                    stall_cnt    <= '0;
                    state        <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A loader that never shows busy must not hang the reader.
                    if (!FILL_DONE_I || (stall_cnt == 2'd3)) begin
                        state <= WAIT_DONE;
                    end else begin
                        stall_cnt <= stall_cnt + 2'd1;
                    end
                end
                WAIT_DONE: begin
                    if (FILL_DONE_I) begin
                        state   <= RUN;
                        READY_O <= 1'b1;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        wptr    <= '0;
                        state   <= REQ_FILL;
                        READY_O <= 1'b0;
                    end
                end
                default: state <= REQ_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_bitstream_reader32.sv
// tb/tb_bitstream_reader32.sv - randomized getbits bench against a bit-queue reference model
`timescale 1ns/1ps
module tb_bitstream_reader32;
    localparam int NW = 512;

    logic        clk = 1'b0;
    logic        resetn;
    logic [8:0]  mem_addr;
    logic        mem_en;
    logic [31:0] mem_data;
    logic        fill_start;
    logic        fill_done;
    logic        req;
    logic [5:0]  nbits;
    logic        peek;
    logic [31:0] bits;
    logic        valid;
    logic        ready;

    always #5 clk = ~clk;

    bitstream_reader32 dut (
        .CLOCK_I       (clk),
        .RESETN_I      (resetn),
        .MEM_ADDRESS_O (mem_addr),
        .MEM_EN_O      (mem_en),
        .MEM_DATA_I    (mem_data),
        .FILL_START_O  (fill_start),
        .FILL_DONE_I   (fill_done),
        .REQ_I         (req),
        .NBITS_I       (nbits),
`ifdef BITSTREAM_PEEK_EN
        .PEEK_I        (peek),
`endif
        .BITS_O        (bits),
        .VALID_O       (valid),
        .READY_O       (ready)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Buffer memory: synchronous read, data one cycle after the enable.
    logic [31:0] mem [NW];
    always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

    // Reference model: the stream is just every loaded word's bits, MSB first.
    bit q[$];
    int mode_q[$];
    int fills = 0;
    int ld_cnt = 0;
    bit no_busy = 1'b0;

    function automatic logic [31:0] model_get(input int n, input bit pk);
        logic [31:0] v;
        v = '0;
        if (n == 0 || n > 32) return '0;
        for (int i = 0; i < n; i++) v = {v[30:0], q[i]};
        if (!pk) for (int i = 0; i < n; i++) void'(q.pop_front());
        return v;
    endfunction

    task automatic load_fill();
        int mode;
        mode = 1;
        if (mode_q.size() > 0) mode = mode_q.pop_front();
        for (int k = 0; k < NW; k++) begin
            if (mode == 0) mem[k] = 32'hA500_0000 | 32'(k);
            else           mem[k] = $urandom;
        end
        if (mode == 2) begin
            mem[0] = 32'h1234_5678;
            mem[1] = 32'h9ABC_DEF0;
        end
        if (mode == 4) mem[0] = 32'hF000_0000;
        for (int k = 0; k < NW; k++)
            for (int b = 31; b >= 0; b--) q.push_back(mem[k][b]);
        no_busy = (mode == 3);
    endtask

    // Loader: START -> DONE low for 3 cycles -> high (mode 3 never drops DONE).
    initial begin
        fill_done = 1'b1;
        forever begin
            @(negedge clk);
            if (fill_start) begin
                fills++;
                load_fill();
                if (!no_busy) begin
                    fill_done = 1'b0;
                    ld_cnt = 3;
                end
            end else if (ld_cnt > 0) begin
                ld_cnt--;
                if (ld_cnt == 0) fill_done = 1'b1;
            end
        end
    end

    // Address monitor: reads walk 0..NUM_WORDS-1, and a refill follows only the last word.
    int exp_addr = 0;
    bit start_prev = 1'b0;
    bit since_reset = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                exp_addr = 0;
                since_reset = 1'b1;
            end else begin
                if (mem_en) begin
                    chk("mem_addr", {23'd0, mem_addr}, exp_addr);
                    exp_addr++;
                end
                if (fill_start) begin
                    chk("start_width", {31'd0, start_prev}, 0);
                    if (!since_reset) chk("start_after_last_word", exp_addr, NW);
                    exp_addr = 0;
                    since_reset = 1'b0;
                end
            end
            start_prev = fill_start;
        end
    end

    logic [31:0] last_bits = '0;

    task automatic do_req(input int n, input bit pk, output logic [31:0] got);
        bit seen;
        req = 1'b1;
        nbits = 6'(n);
        peek = pk;
        seen = 1'b0;
        got = '0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (valid) begin
                got = bits;
                seen = 1'b1;
            end
        end
        req = 1'b0;
        chk("valid_seen", {31'd0, seen}, 1);
        if (seen) chk("bits_vs_model", got, model_get(n, peek));
        last_bits = got;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_mem_en"},   {31'd0, mem_en},     0);
        chk({tag, "_mem_addr"}, {23'd0, mem_addr},   0);
        chk({tag, "_start"},    {31'd0, fill_start}, 0);
        chk({tag, "_bits"},     bits,                0);
        chk({tag, "_valid"},    {31'd0, valid},      0);
        chk({tag, "_ready"},    {31'd0, ready},      0);
    endtask

    task automatic wait_ready(input string tag);
        for (int c = 0; c < 50 && !ready; c++) @(negedge clk);
        chk({tag, "_ready"}, {31'd0, ready}, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        bit addr_seen;
        int f0;
        int n;
        int gap;

        resetn = 1'b0;
        req = 1'b0;
        nbits = '0;
        peek = 1'b0;
        mode_q.push_back(0);
        mode_q.push_back(2);
        mode_q.push_back(1);
        mode_q.push_back(3);
        repeat (3) @(negedge clk);
        check_reset("por");

        resetn = 1'b1;
        @(negedge clk);
        chk("start_first_cycle", {31'd0, fill_start}, 1);
        for (int c = 0; c < 6 && !ready; c++) @(negedge clk);
        chk("ready_after_fill", {31'd0, ready}, 1);
        addr_seen = 1'b0;
        for (int c = 0; c < 6 && !addr_seen; c++) begin
            @(negedge clk);
            if (mem_en) begin
                addr_seen = 1'b1;
                chk("first_addr", {23'd0, mem_addr}, 0);
            end
        end
        chk("first_read_seen", {31'd0, addr_seen}, 1);

        for (int k = 0; k < NW; k++) begin
            do_req(32, 1'b0, got);
            chk("aligned_word", got, 32'hA500_0000 | 32'(k));
        end

        do_req(12, 1'b0, got); chk("straddle_12a", got, 32'h123);
        do_req(12, 1'b0, got); chk("straddle_12b", got, 32'h456);
        do_req(16, 1'b0, got); chk("straddle_16",  got, 32'h789A);
        do_req(24, 1'b0, got); chk("straddle_24",  got, 32'hBCDEF0);

        // 510 words remain: 2331 sevens leave 3 residual bits, the last request straddles the refill.
        f0 = fills;
        for (int i = 0; i < 2332; i++) do_req(7, 1'b0, got);
        chk("refill_count", fills - f0, 1);

        for (int i = 0; i < 1500; i++) begin
            n = $urandom_range(0, 40);
            do_req(n, 1'b0, got);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(negedge clk);
                chk("bits_hold", bits, last_bits);
            end
        end

        // Reset while the reader waits for the loader to finish.
        resetn = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("start_before_wait_done", {31'd0, fill_start}, 1);
        @(negedge clk);
        resetn = 1'b0;
        q.delete();
        @(negedge clk);
        check_reset("rst_wait_done");
        resetn = 1'b1;
        @(negedge clk);
        chk("start_after_rst_wait_done", {31'd0, fill_start}, 1);
        wait_ready("refill_after_rst");

        // Reset in the middle of a request that spans two words.
        do_req(12, 1'b0, got);
        req = 1'b1;
        nbits = 6'd24;
        resetn = 1'b0;
        q.delete();
        @(negedge clk);
        check_reset("rst_straddle");
        req = 1'b0;
        mode_q.delete();
        mode_q.push_back(2);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("start_after_rst_straddle", {31'd0, fill_start}, 1);
        wait_ready("fill_after_rst_straddle");
        do_req(12, 1'b0, got); chk("restart_12a", got, 32'h123);
        do_req(12, 1'b0, got); chk("restart_12b", got, 32'h456);

`ifdef BITSTREAM_PEEK_EN
        resetn = 1'b0;
        q.delete();
        mode_q.delete();
        mode_q.push_back(4);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        wait_ready("peek_fill");
        do_req(4, 1'b1, got); chk("peek_a",       got, 32'hF);
        do_req(4, 1'b1, got); chk("peek_b",       got, 32'hF);
        do_req(4, 1'b0, got); chk("peek_consume", got, 32'hF);
        do_req(4, 1'b0, got); chk("after_peek",   got, 32'h0);
`endif

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bitstream_reader32.md
Name: bitstream_reader32

Overview:
- Downstream consumer of the 32-bit sample buffer filled by memctl32.
- Reads buffer words in order and presents the decoder front end with a getbits interface: request N bits (1..32), receive them MSB-first, right-aligned.
- When all buffer words are consumed, it pulses the loader's START and waits for DONE, then continues from buffer address 0.

Parameters:
- ADDR_W, 9, buffer word-address width. Must match ADDRESS_WIDTH.
- NUM_WORDS, 512, words per fill. Must match the loader's NUM_SAMPLE.
- DATA_W, 32, buffer word width. Fixed at 32.

Ports:
- CLOCK_I  in  1  clock; all logic on rising edge.
- RESETN_I  in  1  reset, synchronous, active-low.
- MEM_ADDRESS_O  out  ADDR_W  buffer read address.
- MEM_EN_O  out  1  buffer read enable.
- MEM_DATA_I  in  32  buffer read data, valid 1 cycle after MEM_EN_O.
- FILL_START_O  out  1  one-cycle pulse to loader START_I.
- FILL_DONE_I  in  1  loader DONE_O: 1 = idle, 0 = filling.
- REQ_I  in  1  getbits request; held high until VALID_O.
- NBITS_I  in  6  bits requested, 1..32; sampled while REQ_I is high.
- BITS_O  out  32  result, right-aligned, upper bits zero.
- VALID_O  out  1  one-cycle pulse; BITS_O is valid in the same cycle.
- READY_O  out  1  high in RUN state (buffer loaded).

Behaviour:
- Reset (RESETN_I=0 at a clock edge, any state): state=REQ_FILL, word pointer=0, bit count=0, 64-bit shift register=0.
- Reset values of outputs: MEM_EN_O=0, MEM_ADDRESS_O=0, FILL_START_O=0, BITS_O=0, VALID_O=0, READY_O=0.
- States:
  - REQ_FILL: drive FILL_START_O=1 for one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for FILL_DONE_I=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for FILL_DONE_I=1, then go to RUN.
  - RUN: normal fetch and extract operation.
- Fill stall guard: if WAIT_BUSY lasts 4 cycles with FILL_DONE_I still 1, go to WAIT_DONE anyway.
- Fetch in RUN:
  - Issue a read when bit count ≤ 32, no read is in flight, and word pointer < NUM_WORDS.
  - A read is MEM_EN_O=1 for one cycle with MEM_ADDRESS_O = word pointer; the pointer increments.
  - The next cycle, MEM_DATA_I is appended directly below the existing valid bits, and bit count += 32.
- Extract:
  - In a cycle with REQ_I=1, no VALID_O this cycle, and bit count ≥ NBITS_I: BITS_O and VALID_O=1 register on the next edge, bit count -= NBITS_I, and the register shifts left by NBITS_I.
  - Latency from REQ_I to VALID_O is 1 cycle when enough bits are available; otherwise it stalls.
  - After VALID_O, the requester drops REQ_I or presents a new request. Back-to-back requests give VALID_O every other cycle at minimum.
- Simultaneous append and extract in one cycle: new count = count − N + 32, with the data positioned correctly. Count never exceeds 64.
- NBITS_I = 0 or > 32 is illegal: VALID_O pulses with BITS_O=0 and nothing is consumed.
- End of buffer: when word pointer = NUM_WORDS and the in-flight read has landed:
  - Word pointer wraps to 0; go to REQ_FILL.
  - Bits still in the register are preserved. Extraction continues from them during the fill, and requests beyond them stall until RUN resumes.
  - READY_O=0 outside RUN.
- BITS_O holds its value between VALID_O pulses.

Optional Feature:
- Macro: BITSTREAM_PEEK_EN.
- Defined:
  - Adds input PEEK_I (1 bit).
  - A request with PEEK_I=1 returns bits exactly as a normal request, but does not decrement bit count or shift (showbits).
- Undefined:
  - No PEEK_I port; every request consumes bits.

Test Plan:
- Fill handshake: reset release → FILL_START_O pulses once on the first cycle after reset; bench loader drives DONE 1→0 (3 cycles)→1 → READY_O=1 within 2 cycles, first MEM_EN_O with address 0.
- Word-aligned reads: buffer word k = 0xA5000000|k; 512 requests of NBITS=32 → BITS_O = 0xA5000000, 0xA5000001, … in order, no repeats or skips.
- Straddling fields: words 0x12345678, 0x9ABCDEF0; requests 12,12,16,24 → 0x123, 0x456, 0x789A, 0xBCDEF0.
- Wrap and refill: consume all 512 words with NBITS=7 requests → FILL_START_O pulses exactly once after the word-511 fetch; residual bits are returned correctly after the refill; the next read uses address 0.
- Reset mid-operation: assert RESETN_I during a straddling request and during WAIT_DONE → all outputs take their reset values at the next edge; a new FILL_START_O pulse follows release.
- Peek (BITSTREAM_PEEK_EN): with word 0xF0000000, PEEK NBITS=4 twice → 0xF both times; then a normal NBITS=4 → 0xF, then NBITS=4 → 0x0.
